cache_miss_ctrl: RTL and testbench

//  Parametrised next-generation cache controller: one FSM for read and write misses, driving

---
 rtl/cache_miss_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss controller for a write-back, write-allocate, direct-mapped data cache.
// Define CACHE_CWF_EN to enable critical-word-first forwarding and hit-under-fill.
module cache_miss_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned NUM_LINES  = 128
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          En,
    input  logic                          RW,
    input  logic [ADDR_W-1:0]             Addr,
    output logic                          Stall,
    input  logic                          C_Miss,
    input  logic                          C_Dirty,
    output logic                          C_Rd,
    output logic                          C_Wr,
    output logic                          C_LineWr,
    output logic                          Merge,
    output logic                          LB_Start,
    input  logic                          LB_WordValid,
    input  logic [$clog2(LINE_WORDS)-1:0] LB_WordIdx,
    input  logic                          LB_Done,
    output logic                          LW_Start,
    input  logic                          LW_Done,
    output logic [ADDR_W-1:0]             MissAddr,
    output logic                          CrtWord,
    output logic                          Busy
);

    localparam int unsigned OFF_W  = $clog2(WORD_BYTES);
    localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned LINE_W = OFF_W + WOFF_W;

`ifdef CACHE_CWF_EN
    localparam bit CwfEn = 1'b1;
`else
    localparam bit CwfEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMiss, StFillWait, StLineWr} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic [WOFF_W-1:0]   miss_off_q, miss_off_d;
    logic                lbp_q, lbp_d;
    logic                lwp_q, lwp_d;
    logic                crit_seen_q, crit_seen_d;
    logic                wr_miss_q, wr_miss_d;
    logic                idx_match;
    logic                crit_hit;
    logic                fill_go;

    assign idx_match = Addr[LINE_W +: IDX_W] == miss_addr_q[LINE_W +: IDX_W];
    // Only a read miss forwards its word, and only the first matching arrival.
    assign crit_hit  = LB_WordValid && (LB_WordIdx == miss_off_q) && !wr_miss_q && !crit_seen_q;
    assign fill_go   = (!lbp_q || LB_Done) && (!lwp_q || LW_Done);

    assign Busy     = (state_q != StIdle);
    assign MissAddr = miss_addr_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        miss_off_d  = miss_off_q;
        lbp_d       = lbp_q;
        lwp_d       = lwp_q;
        crit_seen_d = crit_seen_q;
        wr_miss_d   = wr_miss_q;
        Stall       = 1'b0;
        C_Rd        = 1'b0;
        C_Wr        = 1'b0;
        C_LineWr    = 1'b0;
        Merge       = 1'b0;
        LB_Start    = 1'b0;
        LW_Start    = 1'b0;
        CrtWord     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (En) begin
                    if (!C_Miss) begin
                        C_Rd = !RW;
                        C_Wr = RW;
                    end else begin
                        Stall       = 1'b1;
                        miss_addr_d = {Addr[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
                        miss_off_d  = Addr[OFF_W +: WOFF_W];
                        wr_miss_d   = RW;
                        lbp_d       = 1'b1;
                        lwp_d       = C_Dirty;
                        crit_seen_d = 1'b0;
                        state_d     = StMiss;
                    end
                end
            end
            StMiss: begin
                LB_Start = 1'b1;
                LW_Start = lwp_q;
                Stall    = CwfEn ? 1'b1 : En;
                state_d  = StFillWait;
            end
            StFillWait: begin
                lbp_d = lbp_q && !LB_Done;
                lwp_d = lwp_q && !LW_Done;
                if (fill_go) begin
                    state_d = StLineWr;
                end
                if (!CwfEn) begin
                    Stall = En;
                end else if (crit_hit) begin
                    CrtWord     = 1'b1;
                    crit_seen_d = 1'b1;
                end else if (!crit_seen_q) begin
                    Stall = 1'b1;
                end else if (En) begin
                    // Hit-under-fill: only hits to other lines may proceed.
                    if (C_Miss || idx_match) begin
                        Stall = 1'b1;
                    end else begin
                        C_Rd = !RW;
                        C_Wr = RW;
                    end
                end
            end
            StLineWr: begin
                C_LineWr    = 1'b1;
                Merge       = wr_miss_q;
                Stall       = En;
                lbp_d       = 1'b0;
                lwp_d       = 1'b0;
                crit_seen_d = 1'b0;
                wr_miss_d   = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            miss_off_q  <= '0;
            lbp_q       <= 1'b0;
            lwp_q       <= 1'b0;
            crit_seen_q <= 1'b0;
            wr_miss_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            miss_off_q  <= miss_off_d;
            lbp_q       <= lbp_d;
            lwp_q       <= lwp_d;
            crit_seen_q <= crit_seen_d;
            wr_miss_q   <= wr_miss_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Cycle-vector bench for cache_miss_ctrl; expectations follow CACHE_CWF_EN when defined.
module tb_cache_miss_ctrl;

`ifdef CACHE_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst, En, RW, C_Miss, C_Dirty, LB_WordValid, LB_Done, LW_Done;
    logic [31:0] Addr;
    logic [2:0]  LB_WordIdx;
    logic        Stall, C_Rd, C_Wr, C_LineWr, Merge, LB_Start, LW_Start, CrtWord, Busy;
    logic [31:0] MissAddr;

    always #5 Clk = ~Clk;

    cache_miss_ctrl dut (
        .Clk(Clk), .Rst(Rst), .En(En), .RW(RW), .Addr(Addr), .Stall(Stall),
        .C_Miss(C_Miss), .C_Dirty(C_Dirty), .C_Rd(C_Rd), .C_Wr(C_Wr), .C_LineWr(C_LineWr),
        .Merge(Merge), .LB_Start(LB_Start), .LB_WordValid(LB_WordValid),
        .LB_WordIdx(LB_WordIdx), .LB_Done(LB_Done), .LW_Start(LW_Start), .LW_Done(LW_Done),
        .MissAddr(MissAddr), .CrtWord(CrtWord), .Busy(Busy)
    );

    // exp bit order: Stall C_Rd C_Wr C_LineWr Merge LB_Start LW_Start CrtWord Busy
    typedef struct {
        logic [63:0] tag;
        logic        rst, en, rw;
        logic [31:0] addr;
        logic        miss, dirty, wv;
        logic [2:0]  idx;
        logic        lbd, lwd;
        logic [8:0]  exp;
        logic        ma_chk;
        logic [31:0] ma;
    } vec_t;

    typedef struct {
        logic [63:0] tag;
        int          num;
        logic [8:0]  exp;
        logic        ma_chk;
        logic [31:0] ma;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic v(input logic [63:0] tag, input logic rst, input logic en, input logic rw,
                     input logic [31:0] addr, input logic miss, input logic dirty,
                     input logic wv, input logic [2:0] idx, input logic lbd, input logic lwd,
                     input logic [8:0] exp, input logic ma_chk, input logic [31:0] ma);
        vec_t t;
        t.tag = tag; t.rst = rst; t.en = en; t.rw = rw; t.addr = addr; t.miss = miss;
        t.dirty = dirty; t.wv = wv; t.idx = idx; t.lbd = lbd; t.lwd = lwd; t.exp = exp;
        t.ma_chk = ma_chk; t.ma = ma;
        vecs.push_back(t);
    endtask

    task automatic build_vectors();
        logic [2:0] wi;
        // reset state and plain hits
        v("reset", 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 9'b000000000, 1, 32'h0);
        v("nocyc", 0, 0, 0, 32'h1044, 1, 1, 0, 0, 1, 1, 9'b000000000, 0, 32'h0);
        v("rd_hit", 0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 9'b010000000, 0, 32'h0);
        v("wr_hit", 0, 1, 1, 32'h104, 0, 0, 0, 0, 0, 0, 9'b001000000, 0, 32'h0);
        // clean read miss, offset 1
        v("rmiss", 0, 1, 0, 32'h1044, 1, 0, 0, 0, 0, 0, 9'b100000000, 0, 32'h0);
        v("rmiss", 0, 1, 0, 32'h1044, 1, 0, 0, 0, 0, 0, 9'b100001001, 1, 32'h1040);
        for (int w = 0; w < 8; w++) begin
            wi = w[2:0];
            v("rmiss", 0, 1, 0, 32'h1044, 1, 0, 1, wi, (w == 7), 0,
              (CWF && w == 1) ? 9'b000000011 : 9'b100000001, 0, 32'h0);
        end
        v("rmiss", 0, 1, 0, 32'h1044, 1, 0, 0, 0, 0, 0, 9'b100100001, 1, 32'h1040);
        v("rmiss", 0, 1, 0, 32'h1044, 0, 0, 0, 0, 0, 0, 9'b010000000, 0, 32'h0);
        // dirty write miss, write-back done three cycles before the fill
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 0, 0, 9'b100000000, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 0, 0, 9'b100001101, 1, 32'h2000);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 0, 1, 9'b100000001, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 1, 2, 0, 0, 9'b100000001, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 0, 0, 9'b100000001, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 1, 0, 9'b100000001, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 1, 1, 0, 0, 0, 0, 9'b100110001, 0, 32'h0);
        v("wmiss", 0, 1, 1, 32'h2008, 0, 0, 0, 0, 0, 0, 9'b001000000, 1, 32'h2000);
        // dirty read miss on index 2, hit-under-fill, both dones in one cycle
        v("huf", 0, 1, 0, 32'h5040, 1, 1, 0, 0, 0, 0, 9'b100000000, 0, 32'h0);
        v("huf", 0, 1, 0, 32'h5040, 1, 1, 0, 0, 0, 0, 9'b100001101, 1, 32'h5040);
        v("huf", 0, 1, 0, 32'h5040, 1, 1, 1, 0, 0, 0,
          CWF ? 9'b000000011 : 9'b100000001, 0, 32'h0);
        v("huf", 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 9'b000000001, 0, 32'h0);
        v("huf", 0, 1, 0, 32'h3000, 0, 0, 0, 0, 0, 0,
          CWF ? 9'b010000001 : 9'b100000001, 0, 32'h0);
        v("huf", 0, 1, 1, 32'h3004, 0, 0, 0, 0, 0, 0,
          CWF ? 9'b001000001 : 9'b100000001, 0, 32'h0);
        v("huf", 0, 1, 0, 32'h1050, 0, 0, 0, 0, 0, 0, 9'b100000001, 0, 32'h0);
        v("huf", 0, 1, 0, 32'h1050, 1, 0, 0, 0, 1, 1, 9'b100000001, 0, 32'h0);
        v("huf", 0, 1, 0, 32'h1050, 1, 0, 0, 0, 0, 0, 9'b100100001, 0, 32'h0);
        v("huf", 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 9'b000000000, 0, 32'h0);
        v("huf", 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 9'b000000000, 1, 32'h5040);
        // reset while waiting for the fill
        v("rstfw", 0, 1, 0, 32'h6000, 1, 0, 0, 0, 0, 0, 9'b100000000, 0, 32'h0);
        v("rstfw", 0, 1, 0, 32'h6000, 1, 0, 0, 0, 0, 0, 9'b100001001, 1, 32'h6000);
        v("rstfw", 0, 1, 0, 32'h6000, 1, 0, 0, 0, 0, 0, 9'b100000001, 0, 32'h0);
        v("rstfw", 1, 1, 0, 32'h6000, 1, 0, 0, 0, 0, 0, 9'b100000001, 0, 32'h0);
        v("rstfw", 0, 0, 0, 32'h0,    0, 0, 0, 0, 1, 0, 9'b000000000, 1, 32'h0);
        v("rstfw", 0, 0, 0, 32'h0,    0, 0, 1, 0, 0, 1, 9'b000000000, 0, 32'h0);
        v("rstfw", 0, 1, 0, 32'h6000, 0, 0, 0, 0, 0, 0, 9'b010000000, 0, 32'h0);
    endtask

    initial begin
        sb_t        s;
        logic [8:0] act;
        Rst = 1'b1; En = 1'b0; RW = 1'b0; Addr = '0; C_Miss = 1'b0; C_Dirty = 1'b0;
        LB_WordValid = 1'b0; LB_WordIdx = '0; LB_Done = 1'b0; LW_Done = 1'b0;
        build_vectors();
        repeat (2) @(posedge Clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk);
            #1;
            Rst = vecs[i].rst; En = vecs[i].en; RW = vecs[i].rw; Addr = vecs[i].addr;
            C_Miss = vecs[i].miss; C_Dirty = vecs[i].dirty; LB_WordValid = vecs[i].wv;
            LB_WordIdx = vecs[i].idx; LB_Done = vecs[i].lbd; LW_Done = vecs[i].lwd;
            s.tag = vecs[i].tag; s.num = i; s.exp = vecs[i].exp;
            s.ma_chk = vecs[i].ma_chk; s.ma = vecs[i].ma;
            sb.push_back(s);
            @(negedge Clk);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard[%0d] empty queue, want one entry", i);
            end else begin
                s = sb.pop_front();
                act = {Stall, C_Rd, C_Wr, C_LineWr, Merge, LB_Start, LW_Start, CrtWord, Busy};
                if (act !== s.exp) begin
                    errors++;
                    $display("FAIL %0s[%0d] outputs got %b want %b (Stall..Busy)",
                             s.tag, s.num, act, s.exp);
                end
                if (s.ma_chk) begin
                    checks++;
                    if (MissAddr !== s.ma) begin
                        errors++;
                        $display("FAIL %0s[%0d] MissAddr got %h want %h",
                                 s.tag, s.num, MissAddr, s.ma);
                    end
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
